or_req_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream resource between three requesters.
- The resource is the shared OR/evaluation path.
- The combinational OR of all requests drives a wake/any-request indication.
- The registered FSM issues a one-hot grant, holds it until the owner finishes, enforces a timeout, and rotates priority.
- Sits between the requester blocks and the shared resource; the resource returns a done pulse.

---
 rtl/or_req_rr_arbiter_pkg.sv | 19 +
 rtl/or_req_rr_arbiter_rr_pick3.sv | 34 +++
 rtl/or_req_rr_arbiter.sv | 114 +++++++++++
 tb/tb_or_req_rr_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/or_req_rr_arbiter_pkg.sv
// Shared definitions for the three-way round-robin arbiter and the
// controllers that reuse its pick logic.
package or_req_rr_arbiter_pkg;

  localparam int N_REQ           = 3;
  localparam int DEFAULT_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Circular successor of a requester index, wrapping 2 -> 0.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/or_req_rr_arbiter_rr_pick3.sv
// Combinational circular priority pick among three requesters, starting
// the search at ptr.
module rr_pick3
  import or_req_rr_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] winner,
  output logic       found
);

  logic [1:0] cand0;
  logic [1:0] cand1;
  logic [1:0] cand2;

  always_comb begin
    cand0  = (ptr > 2'd2) ? 2'd0 : ptr;
    cand1  = next_idx(cand0);
    cand2  = next_idx(cand1);
    winner = 2'd0;
    found  = 1'b0;
    if (req[cand0]) begin
      winner = cand0;
      found  = 1'b1;
    end else if (req[cand1]) begin
      winner = cand1;
      found  = 1'b1;
    end else if (req[cand2]) begin
      winner = cand2;
      found  = 1'b1;
    end
  end

endmodule

// File: rtl/or_req_rr_arbiter.sv
// Round-robin owner of the shared OR/evaluation path: one-hot registered
// grant, held until done, withdrawal or timeout, with a dead cycle between owners.
module or_req_rr_arbiter
  import or_req_rr_arbiter_pkg::*;
#(
  parameter int N       = N_REQ,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] gnt,
  output logic [1:0]   owner,
  output logic         busy,
  output logic         any_req,
  output logic         timeout_pulse
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [1:0]    owner_q, owner_d;
  logic          busy_q, busy_d;
  logic          timeout_pulse_q, timeout_pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ptr_q, ptr_d;

  logic [1:0] winner;
  logic       found;
  logic       timeout_hit;
  logic       owner_req;

  assign any_req = |req;

  rr_pick3 u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (winner),
    .found  (found)
  );

  // Counter holds (cycles granted - 1), so the grant lasts exactly TIMEOUT cycles.
  assign timeout_hit = (TIMEOUT != 0) && (int'(cnt_q) == TIMEOUT - 1);
  assign owner_req   = req[owner_q];

  always_comb begin
    state_d         = state_q;
    gnt_d           = gnt_q;
    owner_d         = owner_q;
    busy_d          = busy_q;
    timeout_pulse_d = 1'b0;
    cnt_d           = cnt_q;
    ptr_d           = ptr_q;
    case (state_q)
      IDLE, GAP: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (found) begin
          gnt_d[winner] = 1'b1;
          owner_d       = winner;
          busy_d        = 1'b1;
          cnt_d         = '0;
          state_d       = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (done || !owner_req || timeout_hit) begin
          gnt_d           = '0;
          busy_d          = 1'b0;
          ptr_d           = next_idx(owner_q);
          timeout_pulse_d = !done && owner_req;
          state_d         = GAP;
        end else if (int'(cnt_q) != TIMEOUT) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      gnt_q           <= '0;
      owner_q         <= 2'd0;
      busy_q          <= 1'b0;
      timeout_pulse_q <= 1'b0;
      cnt_q           <= '0;
      ptr_q           <= 2'd0;
    end else begin
      state_q         <= state_d;
      gnt_q           <= gnt_d;
      owner_q         <= owner_d;
      busy_q          <= busy_d;
      timeout_pulse_q <= timeout_pulse_d;
      cnt_q           <= cnt_d;
      ptr_q           <= ptr_d;
    end
  end

  assign gnt           = gnt_q;
  assign owner         = owner_q;
  assign busy          = busy_q;
  assign timeout_pulse = timeout_pulse_q;

endmodule

// File: tb/tb_or_req_rr_arbiter.sv
// Self-checking bench for or_req_rr_arbiter: vector table, hand-written
// corner sequences and a randomized run against a cycle-level model.
module tb_or_req_rr_arbiter;

  localparam int TO = 4;

  logic       clk;
  logic       reset_n;
  logic [2:0] req;
  logic       done;
  logic [2:0] gnt;
  logic [1:0] owner;
  logic       busy;
  logic       any_req;
  logic       timeout_pulse;

  int n_checks;
  int n_fail;

  int m_owner;
  int m_ptr;
  int m_len;
  int m_tp;

  typedef struct {
    logic [2:0] req;
    logic       done;
    logic [2:0] exp_gnt;
    logic [1:0] exp_owner;
    logic       exp_busy;
    logic       exp_tp;
  } vec_t;

  vec_t vecs[26];

  or_req_rr_arbiter #(.N(3), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req           (req),
    .done          (done),
    .gnt           (gnt),
    .owner         (owner),
    .busy          (busy),
    .any_req       (any_req),
    .timeout_pulse (timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic [2:0] eg, input logic [1:0] eo,
                          input logic eb, input logic et);
    checkOutput({tag, " gnt"}, int'(gnt), int'(eg));
    checkOutput({tag, " busy"}, int'(busy), int'(eb));
    checkOutput({tag, " timeout_pulse"}, int'(timeout_pulse), int'(et));
    checkOutput({tag, " any_req"}, int'(any_req), int'(|req));
    if (eb) checkOutput({tag, " owner"}, int'(owner), int'(eo));
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    req     = 3'b000;
    done    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset", 3'b000, 2'd0, 1'b0, 1'b0);
    checkOutput("reset owner", int'(owner), 0);
    reset_n = 1'b1;
    m_owner = -1;
    m_ptr   = 0;
    m_len   = 0;
    m_tp    = 0;
  endtask

  // Reference: owner index or -1, cycles of grant seen so far, and the
  // rotating start point; a release edge never grants, which yields the gap.
  task automatic modelStep(input logic [2:0] r, input logic d);
    m_tp = 0;
    if (m_owner >= 0) begin
      if (d || !r[m_owner]) begin
        m_ptr   = (m_owner + 1) % 3;
        m_owner = -1;
      end else if (TO != 0 && m_len == TO) begin
        m_ptr   = (m_owner + 1) % 3;
        m_owner = -1;
        m_tp    = 1;
      end else begin
        m_len++;
      end
    end else begin
      for (int s = 0; s < 3; s++) begin
        int j;
        j = (m_ptr + s) % 3;
        if (m_owner < 0 && r[j]) begin
          m_owner = j;
          m_len   = 1;
        end
      end
    end
  endtask

  initial begin
    logic [2:0] exp_g;
    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = '{3'b111, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0};
    vecs[1]  = '{3'b111, 1'b1, 3'b000, 2'd0, 1'b0, 1'b0};
    vecs[2]  = '{3'b111, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0};
    vecs[3]  = '{3'b111, 1'b1, 3'b000, 2'd0, 1'b0, 1'b0};
    vecs[4]  = '{3'b111, 1'b0, 3'b100, 2'd2, 1'b1, 1'b0};
    vecs[5]  = '{3'b111, 1'b1, 3'b000, 2'd0, 1'b0, 1'b0};
    vecs[6]  = '{3'b111, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0};
    vecs[7]  = '{3'b111, 1'b1, 3'b000, 2'd0, 1'b0, 1'b0};
    vecs[8]  = '{3'b000, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0};
    vecs[9]  = '{3'b000, 1'b1, 3'b000, 2'd0, 1'b0, 1'b0};
    vecs[10] = '{3'b001, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0};
    vecs[11] = '{3'b001, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0};
    vecs[12] = '{3'b001, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0};
    vecs[13] = '{3'b001, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0};
    vecs[14] = '{3'b001, 1'b0, 3'b000, 2'd0, 1'b0, 1'b1};
    vecs[15] = '{3'b001, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0};
    vecs[16] = '{3'b001, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0};
    vecs[17] = '{3'b001, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0};
    vecs[18] = '{3'b001, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0};
    vecs[19] = '{3'b001, 1'b1, 3'b000, 2'd0, 1'b0, 1'b0};
    vecs[20] = '{3'b000, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0};
    vecs[21] = '{3'b100, 1'b0, 3'b100, 2'd2, 1'b1, 1'b0};
    vecs[22] = '{3'b011, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0};
    vecs[23] = '{3'b011, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0};
    vecs[24] = '{3'b011, 1'b1, 3'b000, 2'd0, 1'b0, 1'b0};
    vecs[25] = '{3'b011, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0};

    reset_n = 1'b0;
    req     = 3'b000;
    done    = 1'b0;
    #2;
    doReset();

    for (int i = 0; i < 26; i++) begin
      applyStimulus(vecs[i].req, vecs[i].done);
      checkAll($sformatf("vec%0d", i), vecs[i].exp_gnt, vecs[i].exp_owner,
               vecs[i].exp_busy, vecs[i].exp_tp);
    end

    // Single requester 2, held for three cycles, then done; pointer ends at 0.
    doReset();
    applyStimulus(3'b100, 1'b0);
    checkAll("single grant", 3'b100, 2'd2, 1'b1, 1'b0);
    applyStimulus(3'b100, 1'b0);
    applyStimulus(3'b100, 1'b0);
    checkAll("single hold", 3'b100, 2'd2, 1'b1, 1'b0);
    applyStimulus(3'b100, 1'b1);
    checkAll("single done", 3'b000, 2'd0, 1'b0, 1'b0);
    applyStimulus(3'b000, 1'b0);
    checkAll("single idle", 3'b000, 2'd0, 1'b0, 1'b0);
    applyStimulus(3'b001, 1'b0);
    checkAll("single ptr wrap", 3'b001, 2'd0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a grant drops it without a clock edge.
    doReset();
    applyStimulus(3'b010, 1'b0);
    checkAll("pre-reset grant", 3'b010, 2'd1, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset gnt", int'(gnt), 0);
    checkOutput("async reset busy", int'(busy), 0);

    // any_req follows req between clock edges.
    doReset();
    req = 3'b100;
    #1;
    checkOutput("any_req comb high", int'(any_req), 1);
    req = 3'b000;
    #1;
    checkOutput("any_req comb low", int'(any_req), 0);

    doReset();
    req  = 3'b000;
    done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      modelStep(req, done);
      #1;
      exp_g = '0;
      if (m_owner >= 0) exp_g[m_owner] = 1'b1;
      checkAll($sformatf("rand%0d", c), exp_g, (m_owner >= 0) ? 2'(m_owner) : 2'd0,
               m_owner >= 0, m_tp != 0);
      if ($urandom_range(3, 0) == 0) req = 3'($urandom_range(7, 0));
      done = ($urandom_range(5, 0) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
